// File: rtl/load_buffer_pkg.sv
// Types and constants shared between the load buffer, its queue, the ROB and the data memory.
package load_buffer_pkg;

   localparam int unsigned ROB_IX_W   = 3;
   localparam int unsigned DATA_DEPTH = 64;

   typedef struct packed {
      logic [ROB_IX_W-1:0] rob_ix;
      logic [31:0]         addr;
   } lb_entry_t;

   typedef enum logic [1:0] {
      LB_IDLE,
      LB_ISSUE,
      LB_WAIT,
      LB_HOLD
   } lb_state_t;

   // Effective byte address; wraps modulo 2^32 by construction.
   function automatic logic [31:0] eff_addr(input logic [31:0] base, input logic [31:0] offset);
      return base + offset;
   endfunction

endpackage

// File: rtl/load_buffer_fifo.sv
// Program-order queue of pending loads, with pointer-MSB full/empty detection and flush.
module load_buffer_fifo
   import load_buffer_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      flush,
   input  logic      push,
   input  lb_entry_t push_data,
   input  logic      pop,
   output lb_entry_t head,
   output logic      full,
   output logic      empty
);

   localparam int unsigned PW    = $clog2(DEPTH);
   localparam int unsigned PTR_W = PW + 1;

   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   lb_entry_t        mem_q [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);

   // Flush wins over both ends of the queue.
   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty && !flush;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else if (flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q[PW-1:0]] <= push_data;
      end
   end

   assign head = mem_q[rd_ptr_q[PW-1:0]];

endmodule

// File: rtl/load_buffer.sv
// Load-side memory responder: queues issued loads, reads the data BRAM one at a time and
// holds each result on a valid/read handshake towards the CDB writer.
module load_buffer #(
   parameter int unsigned DEPTH       = 4,
   parameter int unsigned DATA_DEPTH  = load_buffer_pkg::DATA_DEPTH,
   parameter int unsigned MEM_LATENCY = 2
) (
   input  logic                                  clk_in,
   input  logic                                  rst_in,
   input  logic                                  valid_in,
   input  logic [31:0]                           rval1_in,
   input  logic [31:0]                           rval2_in,
   input  logic [load_buffer_pkg::ROB_IX_W-1:0]  rob_ix_in,
   output logic                                  ready_out,
   input  logic                                  flush_in,
   output logic                                  mem_en_out,
   output logic [$clog2(DATA_DEPTH)-1:0]         mem_addr_out,
   input  logic [31:0]                           mem_data_in,
   output logic                                  valid_out,
   input  logic                                  read_in,
   output logic [load_buffer_pkg::ROB_IX_W-1:0]  rob_ix_out,
   output logic [31:0]                           data_out,
   output logic [31:0]                           addr_out
);

   import load_buffer_pkg::*;

   localparam int unsigned AW = $clog2(DATA_DEPTH);
   localparam int unsigned CW = $clog2(MEM_LATENCY + 1);

   lb_state_t       state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            mem_en_q, mem_en_d;
   logic [AW-1:0]   mem_addr_q, mem_addr_d;
   logic            valid_q, valid_d;
   lb_entry_t       inflight_q, inflight_d;
   lb_entry_t       result_q, result_d;
   logic [31:0]     data_q, data_d;

   logic            fifo_full;
   logic            fifo_empty;
   logic            fifo_pop;
   lb_entry_t       fifo_head;
   lb_entry_t       push_entry;

   assign push_entry = '{rob_ix: rob_ix_in, addr: eff_addr(rval1_in, rval2_in)};
   assign ready_out  = !fifo_full;

   load_buffer_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk_in),
      .rst       (rst_in),
      .flush     (flush_in),
      .push      (valid_in),
      .push_data (push_entry),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      mem_en_d   = 1'b0;
      mem_addr_d = mem_addr_q;
      valid_d    = valid_q;
      inflight_d = inflight_q;
      result_d   = result_q;
      data_d     = data_q;
      fifo_pop   = 1'b0;

      unique case (state_q)
         LB_IDLE: begin
            if (!fifo_empty && !valid_q) begin
               state_d    = LB_ISSUE;
               mem_en_d   = 1'b1;
               mem_addr_d = fifo_head.addr[AW+1:2];
               inflight_d = fifo_head;
               fifo_pop   = 1'b1;
               cnt_d      = CW'(MEM_LATENCY);
            end
         end
         LB_ISSUE: begin
            state_d = LB_WAIT;
            cnt_d   = cnt_q - CW'(1);
         end
         LB_WAIT: begin
            // Counter reaching zero lines up with the BRAM output of the issued read.
            if (cnt_q == '0) begin
               state_d  = LB_HOLD;
               valid_d  = 1'b1;
               data_d   = mem_data_in;
               result_d = inflight_q;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         LB_HOLD: begin
            if (read_in) begin
               state_d = LB_IDLE;
               valid_d = 1'b0;
            end
         end
         default: begin
            state_d = LB_IDLE;
         end
      endcase

      if (flush_in) begin
         state_d  = LB_IDLE;
         valid_d  = 1'b0;
         mem_en_d = 1'b0;
         cnt_d    = '0;
         fifo_pop = 1'b0;
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q    <= LB_IDLE;
         cnt_q      <= '0;
         mem_en_q   <= 1'b0;
         mem_addr_q <= '0;
         valid_q    <= 1'b0;
         inflight_q <= '0;
         result_q   <= '0;
         data_q     <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         mem_en_q   <= mem_en_d;
         mem_addr_q <= mem_addr_d;
         valid_q    <= valid_d;
         inflight_q <= inflight_d;
         result_q   <= result_d;
         data_q     <= data_d;
      end
   end

   assign mem_en_out   = mem_en_q;
   assign mem_addr_out = mem_addr_q;
   assign valid_out    = valid_q;
   assign rob_ix_out   = result_q.rob_ix;
   assign addr_out     = result_q.addr;
   assign data_out     = data_q;

endmodule

// File: tb/tb_load_buffer.sv
// Randomised bench for load_buffer: BRAM model, in-order result scoreboard, directed corner cases.
module tb_load_buffer;

   localparam int DD  = 64;
   localparam int LAT = 2;

   logic        clk_in    = 1'b0;
   logic        rst_in    = 1'b1;
   logic        valid_in  = 1'b0;
   logic [31:0] rval1_in  = '0;
   logic [31:0] rval2_in  = '0;
   logic [2:0]  rob_ix_in = '0;
   logic        flush_in  = 1'b0;
   logic        man_read  = 1'b0;
   logic        rnd_read  = 1'b0;
   logic        auto_read = 1'b0;
   logic        read_in;
   logic        ready_out;
   logic        mem_en_out;
   logic [5:0]  mem_addr_out;
   logic [31:0] mem_data_in;
   logic        valid_out;
   logic [2:0]  rob_ix_out;
   logic [31:0] data_out;
   logic [31:0] addr_out;

   assign read_in = auto_read ? rnd_read : man_read;

   load_buffer #(
      .DEPTH       (4),
      .DATA_DEPTH  (DD),
      .MEM_LATENCY (LAT)
   ) dut (
      .clk_in       (clk_in),
      .rst_in       (rst_in),
      .valid_in     (valid_in),
      .rval1_in     (rval1_in),
      .rval2_in     (rval2_in),
      .rob_ix_in    (rob_ix_in),
      .ready_out    (ready_out),
      .flush_in     (flush_in),
      .mem_en_out   (mem_en_out),
      .mem_addr_out (mem_addr_out),
      .mem_data_in  (mem_data_in),
      .valid_out    (valid_out),
      .read_in      (read_in),
      .rob_ix_out   (rob_ix_out),
      .data_out     (data_out),
      .addr_out     (addr_out)
   );

   always #5 clk_in = ~clk_in;

   // Two-stage BRAM read pipeline
   logic [31:0] mem [DD];
   logic [31:0] bram_r1 = '0;
   logic [31:0] bram_r2 = '0;
   always @(posedge clk_in) begin
      if (mem_en_out) bram_r1 <= mem[mem_addr_out];
      bram_r2 <= bram_r1;
   end
   assign mem_data_in = bram_r2;

   int vectors     = 0;
   int miscompares = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   typedef struct {
      logic [2:0]  rob;
      logic [31:0] addr;
      logic [31:0] data;
   } res_t;

   res_t exp_res  [$];
   int   exp_word [$];

   task automatic model_accept(input logic [31:0] a, input logic [31:0] b, input logic [2:0] rob);
      res_t r;
      int   w;
      r.rob  = rob;
      r.addr = a + b;
      w      = int'(r.addr / 4) % DD;
      r.data = mem[w];
      exp_res.push_back(r);
      exp_word.push_back(w);
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk_in);
         #1;
      end
   endtask

   task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [2:0] rob);
      bit ok = 1'b0;
      valid_in  = 1'b1;
      rval1_in  = a;
      rval2_in  = b;
      rob_ix_in = rob;
      for (int i = 0; i < 200 && !ok; i++) begin
         ok = ready_out;
         tick(1);
      end
      valid_in = 1'b0;
      if (ok) model_accept(a, b, rob);
      else check("push_accept", 32'(ready_out), 32'd1);
   endtask

   task automatic drain();
      for (int i = 0; i < 1000 && (exp_res.size() != 0 || valid_out); i++) tick(1);
      check("drain_empty", 32'(exp_res.size()), 32'd0);
   endtask

   // Scoreboard: issue order, result order/content, hold stability
   bit   seen = 1'b0;
   res_t held;
   always @(negedge clk_in) begin
      if (rst_in) begin
         seen = 1'b0;
      end else begin
         if (mem_en_out) begin
            if (exp_word.size() == 0) check("issue_expected", 32'(exp_word.size()), 32'd1);
            else check("issue_addr", 32'(mem_addr_out), 32'(exp_word.pop_front()));
         end
         if (valid_out && !seen) begin
            seen = 1'b1;
            if (exp_res.size() == 0) begin
               check("result_expected", 32'(exp_res.size()), 32'd1);
            end else begin
               held = exp_res.pop_front();
               check("res_rob", 32'(rob_ix_out), 32'(held.rob));
               check("res_data", data_out, held.data);
               check("res_addr", addr_out, held.addr);
            end
         end else if (valid_out) begin
            check("hold_data", data_out, held.data);
            check("hold_rob", 32'(rob_ix_out), 32'(held.rob));
         end else begin
            seen = 1'b0;
         end
         rnd_read = ($urandom_range(0, 2) == 0);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < DD; i++) mem[i] = $urandom;
      mem[5] = 32'hDEAD_BEEF;

      // Reset state
      tick(3);
      check("rst_valid", 32'(valid_out), 32'd0);
      check("rst_mem_en", 32'(mem_en_out), 32'd0);
      check("rst_mem_addr", 32'(mem_addr_out), 32'd0);
      check("rst_rob", 32'(rob_ix_out), 32'd0);
      check("rst_data", data_out, 32'd0);
      check("rst_addr", addr_out, 32'd0);
      check("rst_ready", 32'(ready_out), 32'd1);
      rst_in = 1'b0;
      tick(1);

      // Single load and its latency
      push(32'd16, 32'd4, 3'd3);
      for (int k = 1; k <= 4; k++) begin
         tick(1);
         check("latency_valid", 32'(valid_out), 32'(k == 4));
      end
      check("t1_data", data_out, 32'hDEAD_BEEF);
      check("t1_rob", 32'(rob_ix_out), 32'd3);
      check("t1_addr", addr_out, 32'd20);

      // Hold without read, then a single read pulse
      tick(10);
      check("hold_valid", 32'(valid_out), 32'd1);
      man_read = 1'b1;
      tick(1);
      man_read = 1'b0;
      check("read_clears", 32'(valid_out), 32'd0);

      // Fill: one load goes in flight, four more fill the queue
      for (int t = 0; t < 5; t++) push($urandom, $urandom_range(0, 255), 3'(t));
      check("full_ready", 32'(ready_out), 32'd0);
      tick(2);
      check("full_ready_held", 32'(ready_out), 32'd0);
      man_read = 1'b1;
      tick(1);
      man_read = 1'b0;
      tick(1);
      check("ready_after_pop", 32'(ready_out), 32'd1);
      auto_read = 1'b1;
      drain();

      // Negative offset, wrap beyond memory, misaligned address
      push(32'd8, 32'hFFFF_FFFC, 3'd5);
      push(32'd264, 32'd0, 3'd6);
      push(32'd22, 32'd0, 3'd7);
      drain();

      // Flush while the first load waits on memory and two more are queued
      auto_read = 1'b0;
      push(32'd0, 32'd0, 3'd1);
      push(32'd4, 32'd0, 3'd2);
      push(32'd8, 32'd0, 3'd3);
      valid_in = 1'b1;
      rval1_in = 32'd12;
      flush_in = 1'b1;
      tick(1);
      flush_in = 1'b0;
      valid_in = 1'b0;
      exp_res.delete();
      exp_word.delete();
      check("flush_ready", 32'(ready_out), 32'd1);
      check("flush_valid", 32'(valid_out), 32'd0);
      check("flush_mem_en", 32'(mem_en_out), 32'd0);
      for (int i = 0; i < 8; i++) begin
         tick(1);
         check("post_flush_quiet", 32'(valid_out), 32'd0);
      end
      push(32'd16, 32'd4, 3'd2);
      auto_read = 1'b1;
      drain();

      // Asynchronous reset in the middle of HOLD
      auto_read = 1'b0;
      push($urandom, $urandom, 3'd1);
      for (int i = 0; i < 20 && !valid_out; i++) tick(1);
      check("pre_reset_valid", 32'(valid_out), 32'd1);
      #2;
      rst_in = 1'b1;
      #1;
      check("async_rst_valid", 32'(valid_out), 32'd0);
      check("async_rst_ready", 32'(ready_out), 32'd1);
      check("async_rst_data", data_out, 32'd0);
      exp_res.delete();
      exp_word.delete();
      #3;
      rst_in = 1'b0;
      tick(1);
      push(32'd16, 32'd4, 3'd4);
      auto_read = 1'b1;
      drain();

      // Random traffic with random consumer back-pressure
      for (int n = 0; n < 40; n++) begin
         push($urandom, $urandom, 3'($urandom_range(0, 7)));
         tick($urandom_range(0, 3));
      end
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
